// File: rtl/vnormalize_if.sv
// rtl/vnormalize_if.sv - handshake bundle for the vector normalizer
//
// Purpose: groups the request side (vector in) and the result side
// (normalized vector out) of vnormalize into one interface.
// Ports:
//   in_valid/in_ready   request handshake
//   x, y, z             signed 20-bit components
//   mag                 unsigned 11-bit floored magnitude
//   out_valid/out_ready result handshake
//   nx, ny, nz          signed 20-bit normalized components
//   div_zero            accepted magnitude was zero
// Modports: master drives requests and consumes results; slave is the block.

interface vnormalize_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [19:0] x;
    logic signed [19:0] y;
    logic signed [19:0] z;
    logic        [10:0] mag;
    logic               out_valid;
    logic               out_ready;
    logic signed [19:0] nx;
    logic signed [19:0] ny;
    logic signed [19:0] nz;
    logic               div_zero;

    modport master (
        output in_valid, x, y, z, mag, out_ready,
        input  in_ready, out_valid, nx, ny, nz, div_zero
    );

    modport slave (
        input  in_valid, x, y, z, mag, out_ready,
        output in_ready, out_valid, nx, ny, nz, div_zero
    );
endinterface

// File: rtl/vnormalize.sv
// rtl/vnormalize.sv - vector normalizer using one shared restoring divider
//
// Purpose: computes c * 2^FRAC / mag for c in x, y, z, one quotient bit per
// cycle, saturating each magnitude at 2^FRAC and restoring the sign.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   vnormalize_if.slave (request and result handshakes)

module vnormalize #(
    parameter int FRAC = 10
) (
    input  logic         clk,
    input  logic         rst,
    vnormalize_if.slave  bus
);
    localparam int W  = 20 + FRAC;
    localparam int CW = $clog2(W);
    localparam logic [19:0] SAT20 = 20'd1 << FRAC;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t          state;
    logic            in_ready_r;
    logic            out_valid_r;
    logic     [19:0] nx_r, ny_r, nz_r;
    logic            div_zero_r;

    logic     [19:0] abs_y, abs_z;
    logic      [2:0] sgn;
    logic     [10:0] mag_r;
    logic    [W-1:0] div_q;          // dividend bits shift out, quotient bits shift in
    logic     [10:0] rem;
    logic   [CW-1:0] bit_cnt;
    logic      [1:0] comp;
    logic     [19:0] res_x, res_y, res_z;
    logic            zero_r;
    // One idle cycle inside DONE before publishing, so the mag=0 path and the
    // divide path both publish two edges after entering DONE.
    logic            settle;

    function automatic logic [19:0] abs20(input logic [19:0] v);
        // -2^19 maps to 20'h80000, which is exact as an unsigned value.
        return v[19] ? (~v + 20'd1) : v;
    endfunction

    logic     [11:0] rem_sh;
    logic     [10:0] rem_diff;
    logic            fits;
    logic    [W-1:0] q_next;
    logic     [19:0] q_mag;
    logic            cur_sgn;
    logic     [19:0] q_signed;

    always_comb begin
        rem_sh   = {rem, div_q[W-1]};
        fits     = (rem_sh >= {1'b0, mag_r});
        // When fits, the true difference is below mag, so 11 bits suffice.
        rem_diff = rem_sh[10:0] - mag_r;
        q_next   = {div_q[W-2:0], fits};
        // mag is floored, so |c| may exceed it; clamp to exactly 1.0.
        q_mag    = (q_next > {{FRAC{1'b0}}, SAT20}) ? SAT20 : q_next[19:0];
        case (comp)
            2'd0:    cur_sgn = sgn[0];
            2'd1:    cur_sgn = sgn[1];
            default: cur_sgn = sgn[2];
        endcase
        q_signed = cur_sgn ? (20'd0 - q_mag) : q_mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            nx_r        <= '0;
            ny_r        <= '0;
            nz_r        <= '0;
            div_zero_r  <= 1'b0;
            settle      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        abs_y      <= abs20(bus.y);
                        abs_z      <= abs20(bus.z);
                        sgn        <= {bus.z[19], bus.y[19], bus.x[19]};
                        mag_r      <= bus.mag;
                        div_q      <= {abs20(bus.x), {FRAC{1'b0}}};
                        rem        <= '0;
                        bit_cnt    <= '0;
                        comp       <= 2'd0;
                        settle     <= 1'b1;
                        if (bus.mag == 11'd0) begin
                            res_x  <= '0;
                            res_y  <= '0;
                            res_z  <= '0;
                            zero_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            zero_r <= 1'b0;
                            state  <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (bit_cnt == CW'(W - 1)) begin
                        // Last bit of this component: finish it and load the next.
                        bit_cnt <= '0;
                        rem     <= '0;
                        case (comp)
                            2'd0: begin
                                res_x <= q_signed;
                                div_q <= {abs_y, {FRAC{1'b0}}};
                                comp  <= 2'd1;
                            end
                            2'd1: begin
                                res_y <= q_signed;
                                div_q <= {abs_z, {FRAC{1'b0}}};
                                comp  <= 2'd2;
                            end
                            default: begin
                                res_z <= q_signed;
                                state <= DONE;
                            end
                        endcase
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                        rem     <= fits ? rem_diff : rem_sh[10:0];
                        div_q   <= q_next;
                    end
                end
                DONE: begin
                    if (settle) begin
                        settle <= 1'b0;
                    end else if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        nx_r        <= res_x;
                        ny_r        <= res_y;
                        nz_r        <= res_z;
                        div_zero_r  <= zero_r;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.nx        = nx_r;
    assign bus.ny        = ny_r;
    assign bus.nz        = nz_r;
    assign bus.div_zero  = div_zero_r;
endmodule

// File: tb/tb_vnormalize.sv
// tb/tb_vnormalize.sv - directed self-checking bench for vnormalize
module tb_vnormalize;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vnormalize_if bus();

    vnormalize #(.FRAC(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int vx, input int vy, input int vz, input int vm);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        bus.x        = 20'(vx);
        bus.y        = 20'(vy);
        bus.z        = 20'(vz);
        bus.mag      = 11'(vm);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.x        = 20'h5A5A5;
        bus.y        = 20'hA5A5A;
        bus.z        = 20'h12345;
        bus.mag      = 11'd3;
    endtask

    task automatic run_vec(input string tag, input int vx, input int vy, input int vz,
                           input int vm, input int lat, input int ex, input int ey,
                           input int ez, input int edz);
        int n;
        accept(vx, vy, vz, vm);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({tag, ".lat"}, n, lat);
        check({tag, ".nx"}, int'(bus.nx), ex);
        check({tag, ".ny"}, int'(bus.ny), ey);
        check({tag, ".nz"}, int'(bus.nz), ez);
        check({tag, ".div_zero"}, int'(bus.div_zero), edz);
        check({tag, ".in_ready_busy"}, int'(bus.in_ready), 0);
        if (bus.out_ready) begin
            tick();
            check({tag, ".ov_drop"}, int'(bus.out_valid), 0);
            check({tag, ".in_ready_back"}, int'(bus.in_ready), 1);
            check({tag, ".nx_held"}, int'(bus.nx), ex);
        end
    endtask

    initial begin
        int n;
        int stable;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.x         = '0;
        bus.y         = '0;
        bus.z         = '0;
        bus.mag       = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset.out_valid", int'(bus.out_valid), 0);
        check("reset.nx", int'(bus.nx), 0);
        check("reset.div_zero", int'(bus.div_zero), 0);
        check("reset.in_ready", int'(bus.in_ready), 1);

        run_vec("v345",   3,  4, 0, 5, 92,  614,  819, 0, 0);
        run_vec("vneg",  -3, -4, 0, 5, 92, -614, -819, 0, 0);
        run_vec("vsat",   6,  0, 0, 5, 92, 1024,    0, 0, 0);
        run_vec("vzero", 100, -7, 3, 0, 2,    0,    0, 0, 1);
        run_vec("vmin", -524288, 0, 524287, 1, 92, -1024, 0, 1024, 0);
        run_vec("vmix", 1000, -1000, 17, 1414, 92, 724, -724, 12, 0);
        run_vec("vmax", 2047, 0, -1, 2047, 92, 1024, 0, 0, 0);

        // Result held under backpressure for 10 cycles.
        bus.out_ready = 1'b0;
        run_vec("stall", 3, 4, 0, 5, 92, 614, 819, 0, 0);
        stable = 1;
        repeat (10) begin
            tick();
            if (!(bus.out_valid === 1'b1 && bus.nx == 614 && bus.ny == 819 &&
                  bus.nz == 0 && bus.div_zero === 1'b0 && bus.in_ready === 1'b0))
                stable = 0;
        end
        check("stall.stable", stable, 1);
        bus.out_ready = 1'b1;
        tick();
        check("stall.ov_drop", int'(bus.out_valid), 0);
        check("stall.in_ready_back", int'(bus.in_ready), 1);

        // Abort mid-divide.
        accept(7, -5, 9, 13);
        repeat (40) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.out_valid", int'(bus.out_valid), 0);
        check("abort.nx", int'(bus.nx), 0);
        check("abort.in_ready", int'(bus.in_ready), 1);
        n = 0;
        repeat (120) begin
            tick();
            if (bus.out_valid === 1'b1) n++;
        end
        check("abort.no_result", n, 0);
        run_vec("after_abort", 3, 4, 0, 5, 92, 614, 819, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vnormalize.md
VNORMALIZE -- requirements
Module: vnormalize

Interface
REQ-001 Parameter FRAC, default 10: number of fraction bits in each normalized output component.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  x, y, z, mag are valid this cycle.
REQ-005 in_ready  output  1  block can accept a vector this cycle.
REQ-006 x, y, z  input  20 each  vector components, two's complement signed.
REQ-007 mag  input  11  unsigned vector magnitude (integer part, floor of sqrt of sum of squares).
REQ-008 out_valid  output  1  nx, ny, nz, div_zero are valid.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 nx, ny, nz  output  20 each  signed normalized components, FRAC fraction bits.
REQ-011 div_zero  output  1  the accepted mag was 0.

Function
REQ-012 in_ready SHALL be 1 only in state IDLE; acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-013 On acceptance, the block SHALL register x, y, z and mag; later input changes SHALL NOT affect the result.
REQ-014 States: IDLE, DIV, DONE; IDLE->DIV on acceptance with mag!=0; IDLE->DONE on acceptance with mag=0; DIV->DONE after the third component completes; DONE->IDLE on out_valid=1 and out_ready=1.
REQ-015 Division SHALL use one shared restoring divider, one quotient bit per cycle, W=20+FRAC cycles per component, components in order x, y, z.
REQ-016 Each component SHALL be q = floor(|c| * 2^FRAC / mag), then saturated to 2^FRAC, then negated if c<0.
REQ-017 |c| of the most-negative input (-2^19) SHALL be computed as 2^19 without overflow.
REQ-018 Saturation SHALL apply because mag is floored and |c| can exceed mag; the result SHALL never exceed +/-2^FRAC.
REQ-019 out_valid SHALL rise exactly 3*W+2 cycles after the acceptance edge when mag!=0, giving 92 cycles for FRAC=10.
REQ-020 If mag=0, the block SHALL output nx=ny=nz=0 and div_zero=1, with out_valid high 2 cycles after acceptance.
REQ-021 div_zero SHALL be 0 for every result with mag!=0.
REQ-022 While out_valid=1 and out_ready=0, nx, ny, nz, div_zero and out_valid SHALL hold stable.
REQ-023 Outputs SHALL change only on entry to DONE; they SHALL retain their last values after the handshake until the next result.
REQ-024 The block SHALL hold no more than one vector in flight; there is no input queue.
REQ-025 The block SHALL accept no new vector in the cycle in which the DONE handshake completes; in_ready SHALL rise the following cycle.

Reset
REQ-026 While rst=1 at a rising edge, the state SHALL become IDLE and out_valid, nx, ny, nz and div_zero SHALL become 0.
REQ-027 in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-028 Reset asserted mid-DIV or in DONE SHALL abort the operation with no result emitted and no stale result after release.
REQ-029 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-030 FRAC=10, x=3, y=4, z=0, mag=5, out_ready=1 -> nx=614, ny=819, nz=0, div_zero=0, out_valid high 92 cycles after acceptance.
REQ-031 x=-3, y=-4, z=0, mag=5 -> nx=-614, ny=-819, nz=0; separately x=6, y=0, z=0, mag=5 -> nx=1024 (saturated).
REQ-032 mag=0 with any x, y, z -> nx=ny=nz=0, div_zero=1, out_valid high 2 cycles after acceptance.
REQ-033 out_ready held 0 for 10 cycles after out_valid rises -> outputs stable, in_ready=0 throughout; the handshake then completes and in_ready=1 one cycle later.
REQ-034 rst pulsed 40 cycles into DIV -> out_valid never rises for that vector, outputs=0, in_ready=1 after release; the next vector (3,4,0,5) produces 614/819/0.
REQ-035 x=-2^19, y=0, z=0, mag=1 -> nx=-1024 (saturated), no overflow.
